freq_meter: RTL and testbench



---
 rtl/freq_meter.sv | 173 +++++++++++++++++
 tb/tb_freq_meter.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/freq_meter.sv
`default_nettype none
// ============================================================================
//  Module      : freq_meter
//  Description : Gated frequency counter. Counts synchronized rising edges of
//                an asynchronous input over back-to-back windows of exactly
//                FREQUENCY_IN / GATE_HZ clock cycles. Reports edges x GATE_HZ
//                in Hz, saturating to all ones on overflow.
//  Revision    : 1.0 - initial release
// ============================================================================
module freq_meter #(
  parameter int FREQUENCY_IN = 50_000_000,
  parameter int GATE_HZ      = 1,
  parameter int COUNT_WIDTH  = 32,
  parameter int SYNC_STAGES  = 2
) (
  input  logic                   Clk,
  input  logic                   Reset,
  input  logic                   SignalIn,
  input  logic                   Enable,
  output logic [COUNT_WIDTH-1:0] Frequency,
  output logic                   Valid,
  output logic                   Overflow,
  output logic                   NoSignal
);

  // Window length in Clk cycles and the derived counter widths.
  localparam int GATE_CYCLES = FREQUENCY_IN / GATE_HZ;
  localparam int GATE_WIDTH  = (GATE_CYCLES > 2) ? $clog2(GATE_CYCLES) : 1;
  // Wide enough that edges x GATE_HZ can never wrap before the range check.
  localparam int PROD_WIDTH  = COUNT_WIDTH + $clog2(GATE_HZ) + 1;

  localparam logic [GATE_WIDTH-1:0]  GATE_LAST = GATE_WIDTH'(GATE_CYCLES - 1);
  localparam logic [COUNT_WIDTH-1:0] COUNT_MAX = '1;
  localparam logic [PROD_WIDTH-1:0]  HZ_WIDE   = PROD_WIDTH'(GATE_HZ);

  // Parameter sanity: an unusable configuration must not elaborate.
  generate
    if (GATE_CYCLES < 2) begin : g_err_gate
      $error("_ERROR_GATE_TOO_SHORT_");
    end
    if (SYNC_STAGES < 2) begin : g_err_sync
      $error("_ERROR_SYNC_TOO_SHALLOW_");
    end
  endgenerate

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    COUNT = 1'b1
  } state_t;

  state_t                   state;
  state_t                   state_next;
  logic [GATE_WIDTH-1:0]    gate;
  logic [GATE_WIDTH-1:0]    gate_next;
  logic [COUNT_WIDTH-1:0]   edges;
  logic [COUNT_WIDTH-1:0]   edges_next;
  logic                     sat;
  logic                     sat_next;

  logic [SYNC_STAGES-1:0]   sync_chain;
  logic                     sync_prev;
  logic                     sync_out;
  logic                     rise;

  logic                     edges_full;
  logic [COUNT_WIDTH-1:0]   edges_sum;
  logic                     sat_sum;
  logic [PROD_WIDTH-1:0]    product;
  logic                     over;
  logic                     window_close;

  // Metastability chain plus previous-sample register; free-running in every state.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      sync_chain <= '0;
      sync_prev  <= 1'b0;
    end else begin
      sync_chain <= {sync_chain[SYNC_STAGES-2:0], SignalIn};
      sync_prev  <= sync_chain[SYNC_STAGES-1];
    end
  end

  assign sync_out = sync_chain[SYNC_STAGES-1];
  assign rise     = sync_out & ~sync_prev;

  // Edge count including this cycle's edge; the counter sticks at all ones
  // and remembers that it did so, which forces Overflow for the window.
  assign edges_full = (edges == COUNT_MAX);
  assign edges_sum  = (rise && !edges_full) ? edges + 1'b1 : edges;
  assign sat_sum    = sat | (rise & edges_full);

  // Scaled result and range check, only consumed when the window closes.
  assign product = PROD_WIDTH'(edges_sum) * HZ_WIDE;
  assign over    = sat_sum | (|product[PROD_WIDTH-1:COUNT_WIDTH]);

  // State, gate counter and edge counter registers.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state <= IDLE;
      gate  <= '0;
      edges <= '0;
      sat   <= 1'b0;
    end else begin
      state <= state_next;
      gate  <= gate_next;
      edges <= edges_next;
      sat   <= sat_next;
    end
  end

  // Window sequencing: idle hold, counting, window close and abort.
  always_comb begin
    state_next   = state;
    gate_next    = gate;
    edges_next   = edges;
    sat_next     = sat;
    window_close = 1'b0;
    case (state)
      IDLE: begin
        gate_next  = '0;
        edges_next = '0;
        sat_next   = 1'b0;
        if (Enable) begin
          state_next = COUNT;
        end
      end
      COUNT: begin
        if (!Enable) begin
          // Abort: partial window is thrown away, results untouched.
          state_next = IDLE;
          gate_next  = '0;
          edges_next = '0;
          sat_next   = 1'b0;
        end else if (gate == GATE_LAST) begin
          // Close and restart in the same cycle so windows abut exactly.
          window_close = 1'b1;
          gate_next    = '0;
          edges_next   = '0;
          sat_next     = 1'b0;
        end else begin
          gate_next  = gate + 1'b1;
          edges_next = edges_sum;
          sat_next   = sat_sum;
        end
      end
      default: begin
        state_next = IDLE;
        gate_next  = '0;
        edges_next = '0;
        sat_next   = 1'b0;
      end
    endcase
  end

  // Result registers, loaded at window close; Valid marks the update cycle.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      Frequency <= '0;
      Valid     <= 1'b0;
      Overflow  <= 1'b0;
      NoSignal  <= 1'b0;
    end else begin
      Valid <= window_close;
      if (window_close) begin
        Frequency <= over ? COUNT_MAX : product[COUNT_WIDTH-1:0];
        Overflow  <= over;
        NoSignal  <= (edges_sum == '0);
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_freq_meter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_freq_meter
//  Description : Self-checking bench for freq_meter. Two instances: a 100-cycle
//                window at 10 Hz gate rate and a 50-cycle window at 20 Hz.
//                Expected results come from a window-level model that counts
//                driven rising transitions by their detection time.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_freq_meter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       sig_a, en_a, sig_b, en_b;
  logic [7:0] freq_a, freq_b;
  logic       valid_a, ovf_a, nos_a;
  logic       valid_b, ovf_b, nos_b;

  freq_meter #(.FREQUENCY_IN(1000), .GATE_HZ(10), .COUNT_WIDTH(8), .SYNC_STAGES(2)) dut_a (
    .Clk(clk), .Reset(rst_n), .SignalIn(sig_a), .Enable(en_a),
    .Frequency(freq_a), .Valid(valid_a), .Overflow(ovf_a), .NoSignal(nos_a)
  );

  freq_meter #(.FREQUENCY_IN(1000), .GATE_HZ(20), .COUNT_WIDTH(8), .SYNC_STAGES(2)) dut_b (
    .Clk(clk), .Reset(rst_n), .SignalIn(sig_b), .Enable(en_b),
    .Frequency(freq_b), .Valid(valid_b), .Overflow(ovf_b), .NoSignal(nos_b)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int fails  = 0;

  // Reference model state: per instance window length, gate rate, arming.
  int         gc [2] = '{100, 50};
  int         hz [2] = '{10, 20};
  bit         active [2];
  int         e0 [2];
  bit         last_sig [2];
  int         rises0 [$];
  int         rises1 [$];
  bit         exp_valid [2];
  bit         exp_ovf [2];
  bit         exp_nos [2];
  logic [7:0] exp_freq [2];

  // A rise driven after edge n is seen by the counter in the cycle after edge
  // n+2; count those whose detection cycle lies in [lo, hi).
  function automatic int count_edges(input int d, input int lo, input int hi);
    int n = 0;
    if (d == 0) begin
      foreach (rises0[i]) if (rises0[i] + 2 >= lo && rises0[i] + 2 < hi) n++;
    end else begin
      foreach (rises1[i]) if (rises1[i] + 2 >= lo && rises1[i] + 2 < hi) n++;
    end
    return n;
  endfunction

  // Drive one cycle of inputs for instance d, advance a clock, update model.
  task automatic step(input int d, input bit s, input bit e);
    int c;
    int n;
    if (d == 0) begin sig_a = s; en_a = e; end
    else begin sig_b = s; en_b = e; end
    if (rst_n && s && !last_sig[d]) begin
      if (d == 0) rises0.push_back(cyc);
      else rises1.push_back(cyc);
    end
    last_sig[d] = rst_n ? s : 1'b0;
    @(posedge clk);
    #1;
    c = cyc;
    exp_valid[0] = 1'b0;
    exp_valid[1] = 1'b0;
    if (!rst_n) begin
      for (int k = 0; k < 2; k++) begin
        active[k] = 1'b0; exp_freq[k] = 8'd0; exp_ovf[k] = 1'b0;
        exp_nos[k] = 1'b0; last_sig[k] = 1'b0;
      end
      rises0.delete();
      rises1.delete();
    end else if (!active[d]) begin
      if (e) begin active[d] = 1'b1; e0[d] = c; end
    end else if (!e) begin
      active[d] = 1'b0;
    end else if ((c - e0[d]) % gc[d] == 0) begin
      n = count_edges(d, c - gc[d], c);
      exp_valid[d] = 1'b1;
      exp_ovf[d]   = (n * hz[d] > 255);
      exp_freq[d]  = exp_ovf[d] ? 8'hFF : 8'(n * hz[d]);
      exp_nos[d]   = (n == 0);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(0, 1'b0, 1'b1);
      if ({valid_a, ovf_a, nos_a, freq_a, valid_b, ovf_b, nos_b, freq_b} !== 22'd0) begin
        fails++;
        $display("FAIL reset_state cyc=%0d actual a v/o/n/f=%b/%b/%b/%0d b=%b/%b/%b/%0d required all 0",
                 cyc, valid_a, ovf_a, nos_a, freq_a, valid_b, ovf_b, nos_b, freq_b);
      end
      checks++;
    end
    rst_n = 1'b1;
    for (int i = 0; i <= 100; i++) begin
      step(0, 1'b0, 1'b1);
      if ({valid_a, ovf_a, nos_a, freq_a} !== {exp_valid[0], exp_ovf[0], exp_nos[0], exp_freq[0]}) begin
        fails++;
        $display("FAIL reset_release cyc=%0d actual v/o/n/f=%b/%b/%b/%0d required %b/%b/%b/%0d",
                 cyc, valid_a, ovf_a, nos_a, freq_a, exp_valid[0], exp_ovf[0], exp_nos[0], exp_freq[0]);
      end
      checks++;
      if (valid_a !== (i == 100)) begin
        fails++;
        $display("FAIL reset_first_valid step=%0d actual %b required %b", i, valid_a, (i == 100));
      end
      checks++;
    end
  endtask

  task automatic test_nominal();
    int nvalid;
    int last_v;
    nvalid = 0;
    last_v = 0;
    step(0, 1'b0, 1'b0);
    for (int i = 0; i <= 300; i++) begin
      step(0, (i % 10) < 5, 1'b1);
      if ({valid_a, ovf_a, nos_a, freq_a} !== {exp_valid[0], exp_ovf[0], exp_nos[0], exp_freq[0]}) begin
        fails++;
        $display("FAIL nominal cyc=%0d actual v/o/n/f=%b/%b/%b/%0d required %b/%b/%b/%0d",
                 cyc, valid_a, ovf_a, nos_a, freq_a, exp_valid[0], exp_ovf[0], exp_nos[0], exp_freq[0]);
      end
      checks++;
      if (valid_a === 1'b1) begin
        if (freq_a !== 8'd100 || ovf_a !== 1'b0 || nos_a !== 1'b0) begin
          fails++;
          $display("FAIL nominal_value actual f/o/n=%0d/%b/%b required 100/0/0", freq_a, ovf_a, nos_a);
        end
        checks++;
        if ((nvalid == 0 && i != 100) || (nvalid > 0 && i - last_v != 100)) begin
          fails++;
          $display("FAIL nominal_spacing actual step %0d (previous %0d) required multiple of 100", i, last_v);
        end
        checks++;
        nvalid++;
        last_v = i;
      end
    end
    if (nvalid != 3) begin
      fails++;
      $display("FAIL nominal_count actual %0d required 3", nvalid);
    end
    checks++;
  endtask

  task automatic test_no_signal();
    int nvalid;
    nvalid = 0;
    for (int i = 0; i < 300; i++) begin
      step(0, 1'b1, 1'b1);
      if ({valid_a, ovf_a, nos_a, freq_a} !== {exp_valid[0], exp_ovf[0], exp_nos[0], exp_freq[0]}) begin
        fails++;
        $display("FAIL no_signal cyc=%0d actual v/o/n/f=%b/%b/%b/%0d required %b/%b/%b/%0d",
                 cyc, valid_a, ovf_a, nos_a, freq_a, exp_valid[0], exp_ovf[0], exp_nos[0], exp_freq[0]);
      end
      checks++;
      if (valid_a === 1'b1) begin
        if (nvalid > 0 && (freq_a !== 8'd0 || nos_a !== 1'b1)) begin
          fails++;
          $display("FAIL no_signal_value actual f/n=%0d/%b required 0/1", freq_a, nos_a);
        end
        checks++;
        nvalid++;
      end
    end
    if (nvalid != 3) begin
      fails++;
      $display("FAIL no_signal_count actual %0d required 3", nvalid);
    end
    checks++;
  endtask

  task automatic test_overflow();
    int nvalid;
    nvalid = 0;
    step(0, 1'b0, 1'b0);
    for (int i = 0; i <= 200; i++) begin
      step(0, (i % 4) < 2, 1'b1);
      if ({valid_a, ovf_a, nos_a, freq_a} !== {exp_valid[0], exp_ovf[0], exp_nos[0], exp_freq[0]}) begin
        fails++;
        $display("FAIL overflow_edge cyc=%0d actual v/o/n/f=%b/%b/%b/%0d required %b/%b/%b/%0d",
                 cyc, valid_a, ovf_a, nos_a, freq_a, exp_valid[0], exp_ovf[0], exp_nos[0], exp_freq[0]);
      end
      checks++;
      if (valid_a === 1'b1) begin
        if (freq_a !== 8'd250 || ovf_a !== 1'b0) begin
          fails++;
          $display("FAIL overflow_edge_value actual f/o=%0d/%b required 250/0", freq_a, ovf_a);
        end
        checks++;
        nvalid++;
      end
    end
    step(0, 1'b0, 1'b0);
    for (int i = 0; i <= 150; i++) begin
      step(1, (i % 2) == 0, 1'b1);
      if ({valid_b, ovf_b, nos_b, freq_b} !== {exp_valid[1], exp_ovf[1], exp_nos[1], exp_freq[1]}) begin
        fails++;
        $display("FAIL overflow_sat cyc=%0d actual v/o/n/f=%b/%b/%b/%0d required %b/%b/%b/%0d",
                 cyc, valid_b, ovf_b, nos_b, freq_b, exp_valid[1], exp_ovf[1], exp_nos[1], exp_freq[1]);
      end
      checks++;
      if (valid_b === 1'b1) begin
        if (freq_b !== 8'd255 || ovf_b !== 1'b1) begin
          fails++;
          $display("FAIL overflow_sat_value actual f/o=%0d/%b required 255/1", freq_b, ovf_b);
        end
        checks++;
        nvalid++;
      end
    end
    step(1, 1'b0, 1'b0);
    if (nvalid != 5) begin
      fails++;
      $display("FAIL overflow_count actual %0d required 5", nvalid);
    end
    checks++;
  endtask

  task automatic test_abort();
    int nvalid;
    bit e;
    nvalid = 0;
    step(0, 1'b0, 1'b0);
    for (int i = 0; i <= 266; i++) begin
      e = !(i >= 160 && i < 165);
      step(0, (i % 10) < 5, e);
      if ({valid_a, ovf_a, nos_a, freq_a} !== {exp_valid[0], exp_ovf[0], exp_nos[0], exp_freq[0]}) begin
        fails++;
        $display("FAIL abort cyc=%0d actual v/o/n/f=%b/%b/%b/%0d required %b/%b/%b/%0d",
                 cyc, valid_a, ovf_a, nos_a, freq_a, exp_valid[0], exp_ovf[0], exp_nos[0], exp_freq[0]);
      end
      checks++;
      if (valid_a === 1'b1) begin
        if (i != 100 && i != 265) begin
          fails++;
          $display("FAIL abort_valid_time actual step %0d required 100 or 265", i);
        end
        checks++;
        nvalid++;
      end
      if (i == 200) begin
        if (valid_a !== 1'b0 || freq_a !== 8'd100) begin
          fails++;
          $display("FAIL abort_hold actual v/f=%b/%0d required 0/100", valid_a, freq_a);
        end
        checks++;
      end
    end
    if (nvalid != 2) begin
      fails++;
      $display("FAIL abort_count actual %0d required 2", nvalid);
    end
    checks++;
  endtask

  task automatic test_boundary();
    bit s;
    step(0, 1'b0, 1'b0);
    for (int i = 0; i <= 300; i++) begin
      s = (i >= 98 && i < 103) || (i >= 199 && i < 204);
      step(0, s, 1'b1);
      if ({valid_a, ovf_a, nos_a, freq_a} !== {exp_valid[0], exp_ovf[0], exp_nos[0], exp_freq[0]}) begin
        fails++;
        $display("FAIL boundary cyc=%0d actual v/o/n/f=%b/%b/%b/%0d required %b/%b/%b/%0d",
                 cyc, valid_a, ovf_a, nos_a, freq_a, exp_valid[0], exp_ovf[0], exp_nos[0], exp_freq[0]);
      end
      checks++;
      if (i == 100 || i == 200 || i == 300) begin
        if (valid_a !== 1'b1 || freq_a !== ((i == 200) ? 8'd0 : 8'd10)) begin
          fails++;
          $display("FAIL boundary_window step=%0d actual v/f=%b/%0d required 1/%0d",
                   i, valid_a, freq_a, (i == 200) ? 0 : 10);
        end
        checks++;
      end
    end
  endtask

  task automatic test_random();
    bit lvl;
    bit e;
    int run;
    int nv;
    lvl = 1'b0;
    run = 0;
    nv  = 0;
    step(0, 1'b0, 1'b0);
    for (int i = 0; i < 700; i++) begin
      if (run == 0) begin
        lvl = ~lvl;
        run = $urandom_range(2, 14);
      end
      run--;
      e = (i >= 300) || ($urandom_range(0, 149) != 0);
      step(0, lvl, e);
      if ({valid_a, ovf_a, nos_a, freq_a} !== {exp_valid[0], exp_ovf[0], exp_nos[0], exp_freq[0]}) begin
        fails++;
        $display("FAIL random cyc=%0d actual v/o/n/f=%b/%b/%b/%0d required %b/%b/%b/%0d",
                 cyc, valid_a, ovf_a, nos_a, freq_a, exp_valid[0], exp_ovf[0], exp_nos[0], exp_freq[0]);
      end
      checks++;
      if (valid_a === 1'b1) nv++;
    end
    if (nv < 3) begin
      fails++;
      $display("FAIL random_valids actual %0d required at least 3", nv);
    end
    checks++;
  endtask

  initial begin
    rst_n = 1'b0;
    sig_a = 1'b0;
    en_a  = 1'b0;
    sig_b = 1'b0;
    en_b  = 1'b0;
    test_reset();
    test_nominal();
    test_no_signal();
    test_overflow();
    test_abort();
    test_boundary();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
`default_nettype wire
